// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard and stall controller sitting beside the ID stage.
// Handles multi-bubble load latency, D-cache freeze, branch flush and a stall-cycle counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no stall in progress; hazard/branch detection active
// LU_STALL | inserting remaining load-use bubbles (bub_cnt left, >= 1)
module hazard_stall_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              ALUSrc_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  input  logic              Branch_i,
  input  logic              DCacheStall_i,
  input  logic              ClrCnt_i,
  output logic              PCWrite_o,
  output logic              Stall_o,
  output logic              NoOp_o,
  output logic              Flush_o,
  output logic              Freeze_o,
  output logic              Busy_o,
  output logic [CNT_W-1:0]  StallCount_o
);

  if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_lat
    $error("hazard_stall_ctrl: LOAD_LAT must be in 1..15");
  end

  typedef enum logic {IDLE, LU_STALL} state_t;

  state_t     state, state_nxt;
  logic [3:0] bub_cnt, bub_cnt_nxt;
  logic       haz;
  logic       pcw, stall, noop, flush;

  assign haz = MemRead_i && (RDaddr_i != '0) &&
               ((RDaddr_i == RS1addr_i) || ((RDaddr_i == RS2addr_i) && !ALUSrc_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      bub_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bub_cnt_nxt = bub_cnt;
    pcw         = 1'b1;
    stall       = 1'b0;
    noop        = 1'b0;
    flush       = 1'b0;
    // a frozen pipeline holds everything; the hazard is re-evaluated after release
    if (DCacheStall_i) begin
      pcw = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (haz) begin
            pcw   = 1'b0;
            stall = 1'b1;
            noop  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt   = LU_STALL;
              bub_cnt_nxt = 4'(LOAD_LAT - 1);
            end
          end else begin
            flush = Branch_i;
          end
        end
        LU_STALL: begin
          pcw   = 1'b0;
          stall = 1'b1;
          noop  = 1'b1;
          if (bub_cnt == 4'd1) begin
            state_nxt   = IDLE;
            bub_cnt_nxt = '0;
          end else begin
            bub_cnt_nxt = bub_cnt - 4'd1;
          end
        end
        default: begin
          state_nxt   = IDLE;
          bub_cnt_nxt = '0;
        end
      endcase
    end
  end

  // outputs pinned to the safe run state while reset is held
  assign PCWrite_o = pcw | !rst_i;
  assign Stall_o   = stall & rst_i;
  assign NoOp_o    = noop & rst_i;
  assign Flush_o   = flush & rst_i;
  assign Freeze_o  = DCacheStall_i & rst_i;
  assign Busy_o    = (state == LU_STALL) & rst_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      StallCount_o <= '0;
    end else if (ClrCnt_i) begin
      StallCount_o <= '0;
    end else if ((Stall_o || Freeze_o) && (StallCount_o != '1)) begin
      StallCount_o <= StallCount_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LOAD_LAT=1/CNT_W=4 and LOAD_LAT=3/CNT_W=32)
// share stimulus; expected flags and counts go through a scoreboard queue.
module tb_hazard_stall_ctrl;

  typedef struct {
    logic       rst, mem, alu;
    logic [4:0] rd, rs1, rs2;
    logic       br, dc, clr;
    logic [5:0] e1, e3;
    int         c1, c3;
  } vec_t;

  typedef struct {
    logic [5:0] e1, e3;
    int         c1, c3;
    int         idx;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic mem = 0, alu = 0, br = 0, dc = 0, clr = 0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;

  logic pcw1, st1, nop1, fl1, fz1, bz1;
  logic pcw3, st3, nop3, fl3, fz3, bz3;
  logic [3:0]  cnt1;
  logic [31:0] cnt3;
  logic [5:0]  f1, f3;

  assign f1 = {pcw1, st1, nop1, fl1, fz1, bz1};
  assign f3 = {pcw3, st3, nop3, fl3, fz3, bz3};

  int n_pass = 0;
  int n_total = 0;
  int step_no = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk_i = ~clk_i;

  hazard_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(4)) u_lat1 (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(mem), .ALUSrc_i(alu),
    .RDaddr_i(rd), .RS1addr_i(rs1), .RS2addr_i(rs2), .Branch_i(br),
    .DCacheStall_i(dc), .ClrCnt_i(clr),
    .PCWrite_o(pcw1), .Stall_o(st1), .NoOp_o(nop1), .Flush_o(fl1),
    .Freeze_o(fz1), .Busy_o(bz1), .StallCount_o(cnt1)
  );

  hazard_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(32)) u_lat3 (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(mem), .ALUSrc_i(alu),
    .RDaddr_i(rd), .RS1addr_i(rs1), .RS2addr_i(rs2), .Branch_i(br),
    .DCacheStall_i(dc), .ClrCnt_i(clr),
    .PCWrite_o(pcw3), .Stall_o(st3), .NoOp_o(nop3), .Flush_o(fl3),
    .Freeze_o(fz3), .Busy_o(bz3), .StallCount_o(cnt3)
  );

  function automatic vec_t mk(input logic r, input logic m, input logic a,
                              input int d, input int s1, input int s2,
                              input logic b, input logic c, input logic k,
                              input logic [5:0] x1, input logic [5:0] x3,
                              input int n1, input int n3);
    vec_t v;
    v.rst = r; v.mem = m; v.alu = a;
    v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2);
    v.br = b; v.dc = c; v.clr = k;
    v.e1 = x1; v.e3 = x3; v.c1 = n1; v.c3 = n3;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s step %0d: got %0h want %0h", name, idx, got, want);
  endtask

  // flags order: {PCWrite, Stall, NoOp, Flush, Freeze, Busy}
  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = v.rst; mem = v.mem; alu = v.alu;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    br = v.br; dc = v.dc; clr = v.clr;
    sb.push_back('{e1: v.e1, e3: v.e3, c1: v.c1, c3: v.c3, idx: step_no});
    step_no++;
    @(negedge clk_i);
    e = sb.pop_front();
    chk("flags_lat1", e.idx, 32'(f1), 32'(e.e1));
    chk("flags_lat3", e.idx, 32'(f3), 32'(e.e3));
    chk("count_lat1", e.idx, 32'(cnt1), 32'(e.c1));
    chk("count_lat3", e.idx, cnt3, 32'(e.c3));
  endtask

  initial begin
    //            rst mem alu rd rs1 rs2 br dc clr  lat1       lat3       c1 c3
    tbl.push_back(mk(0, 1, 0, 5, 5, 0, 1, 1, 0, 6'b100000, 6'b100000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b100000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b100000, 0, 0));
    // load-use on rs1
    tbl.push_back(mk(1, 1, 0, 5, 5, 0, 0, 0, 0, 6'b011000, 6'b011000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b011001, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b011001, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b100000, 1, 3));
    // load-use on rs2
    tbl.push_back(mk(1, 1, 0, 7, 0, 7, 0, 0, 0, 6'b011000, 6'b011000, 1, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b011001, 2, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b011001, 2, 5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100000, 6'b100000, 2, 6));
    // filters: x0, immediate rs2, branch alone, not a load
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b100000, 0, 0));
    tbl.push_back(mk(1, 1, 1, 7, 3, 7, 0, 0, 0, 6'b100000, 6'b100000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100100, 6'b100100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 5, 5, 0, 0, 0, 0, 6'b100000, 6'b100000, 0, 0));
    // hazard + branch, then branch re-resolves; lat3 ignores detection while busy
    tbl.push_back(mk(1, 1, 0, 9, 9, 0, 1, 0, 0, 6'b011000, 6'b011000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 6'b100100, 6'b011001, 1, 1));
    tbl.push_back(mk(1, 1, 0, 4, 4, 0, 0, 0, 0, 6'b011000, 6'b011001, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b100000, 2, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100000, 6'b100000, 2, 3));
    // freeze during second bubble
    tbl.push_back(mk(1, 1, 0, 7, 0, 7, 0, 0, 0, 6'b011000, 6'b011000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000010, 6'b000011, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000010, 6'b000011, 2, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b011001, 3, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b011001, 3, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b100000, 3, 5));
    // freeze on top of a fresh hazard defers it
    tbl.push_back(mk(1, 1, 0, 6, 6, 0, 0, 1, 0, 6'b000010, 6'b000010, 3, 5));
    tbl.push_back(mk(1, 1, 0, 6, 6, 0, 0, 0, 0, 6'b011000, 6'b011000, 4, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b011001, 5, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b011001, 5, 8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100000, 6'b100000, 5, 9));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // held hazard: 4-bit counter saturates at 15, wide one keeps counting
    for (int i = 0; i < 20; i++)
      step(mk(1, 1, 0, 6, 6, 0, 0, 0, 0, 6'b011000,
              (i % 3 == 0) ? 6'b011000 : 6'b011001, (i > 15) ? 15 : i, i));
    step(mk(1, 1, 0, 6, 6, 0, 0, 0, 1, 6'b011000, 6'b011001, 15, 20));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b100000, 0, 0));

    // reset during LU_STALL abandons remaining bubbles
    step(mk(1, 1, 0, 8, 8, 0, 0, 0, 0, 6'b011000, 6'b011000, 0, 0));
    step(mk(0, 1, 0, 8, 8, 0, 1, 1, 0, 6'b100000, 6'b100000, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b100000, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 6'b100000, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised load-use hazard and pipeline-stall controller for the 5-stage pipelined CPU.
- Sits beside the ID stage and drives PC write-enable, IF/ID hold, ID/EX bubble insertion, IF/ID flush and whole-pipeline freeze.
- Generalises single-cycle load-use detection in four ways:
  - configurable load-to-use latency (multi-bubble stalls, tracked by a state machine);
  - x0 exclusion;
  - data-cache freeze handling and branch-flush arbitration;
  - a saturating stall-cycle performance counter.

Parameters:
- ADDR_W, 5: register address width.
- LOAD_LAT, 1: number of bubbles inserted per load-use hazard. Legal range 1..15; elaboration error outside this range.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- MemRead_i  in  1  instruction in EX is a load.
- ALUSrc_i  in  1  ID instruction uses an immediate as its second operand (RS2 unused).
- RDaddr_i  in  ADDR_W  destination register of the EX instruction.
- RS1addr_i  in  ADDR_W  rs1 of the ID instruction.
- RS2addr_i  in  ADDR_W  rs2 of the ID instruction.
- Branch_i  in  1  branch resolved taken in ID this cycle.
- DCacheStall_i  in  1  data memory not ready; whole pipeline must freeze.
- ClrCnt_i  in  1  synchronous clear of StallCount_o.
- PCWrite_o  out  1  PC write enable.
- Stall_o  out  1  hold IF/ID register.
- NoOp_o  out  1  insert a bubble into ID/EX.
- Flush_o  out  1  flush IF/ID (taken branch).
- Freeze_o  out  1  freeze all pipeline registers and PC.
- Busy_o  out  1  multi-cycle load-use stall in progress (state LU_STALL).
- StallCount_o  out  CNT_W  stall/freeze cycle counter.

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE, internal bubble counter=0, StallCount_o=0. While rst_i is low, the outputs are forced to PCWrite_o=1 and Stall_o=NoOp_o=Flush_o=Freeze_o=Busy_o=0, regardless of the other inputs.
- Hazard detect (combinational): haz = MemRead_i & (RDaddr_i!=0) & ((RDaddr_i==RS1addr_i) | (RDaddr_i==RS2addr_i & !ALUSrc_i)). A destination of x0 never causes a stall.
- Freeze has top priority:
  - Freeze_o = DCacheStall_i (combinational, same cycle).
  - While frozen: PCWrite_o=0, Stall_o=0, NoOp_o=0, Flush_o=0.
  - State and bubble counter hold; a hazard or branch seen during freeze is evaluated again once freeze drops.
- State IDLE, not frozen:
  - haz=1: PCWrite_o=0, Stall_o=1, NoOp_o=1, Flush_o=0. If LOAD_LAT>1, next state=LU_STALL with counter=LOAD_LAT-1; otherwise stay in IDLE.
  - haz=0: PCWrite_o=1, Stall_o=0, NoOp_o=0, Flush_o=Branch_i.
  - haz and Branch_i together: the hazard wins and Flush_o=0. The branch re-resolves after the stall.
- State LU_STALL, not frozen:
  - Outputs: PCWrite_o=0, Stall_o=1, NoOp_o=1, Flush_o=0, Busy_o=1. Detection inputs are ignored; the load has already advanced.
  - Counter decrements each cycle. When counter==1, next state=IDLE and counter=0.
  - Total consecutive bubble cycles per hazard = LOAD_LAT.
- Busy_o = (state==LU_STALL), including while frozen.
- StallCount_o:
  - Increments by 1 on each rising edge where Stall_o | Freeze_o was 1 in that cycle.
  - Saturates at all-ones, no wrap.
  - ClrCnt_i has priority over the increment and sets the counter to 0 on the next edge.
- Reset asserted mid-LU_STALL returns the block to IDLE immediately; the remaining bubbles are abandoned.

Test Plan:
- Reset then idle: rst_i low for 2 cycles, then released with all inputs 0 -> PCWrite_o=1, all other outputs 0, StallCount_o=0.
- Basic load-use, LOAD_LAT=1: MemRead_i=1, RDaddr_i=5, RS1addr_i=5 for 1 cycle -> exactly 1 cycle of PCWrite_o=0/Stall_o=1/NoOp_o=1, then normal operation; StallCount_o=1.
- Multi-bubble, LOAD_LAT=3: RDaddr_i=7, RS2addr_i=7, ALUSrc_i=0 for 1 cycle -> 3 consecutive stall cycles, Busy_o=1 on cycles 2-3, StallCount_o=3.
- Filters, LOAD_LAT=1:
  - RDaddr_i=0, RS1addr_i=0 with MemRead_i=1 -> no stall.
  - RDaddr_i=7, RS2addr_i=7, ALUSrc_i=1 -> no stall.
  - Hazard plus Branch_i=1 in the same cycle -> stall and Flush_o=0.
  - Branch_i alone -> Flush_o=1.
- Freeze mid-stall, LOAD_LAT=3: DCacheStall_i=1 for 2 cycles during the second bubble -> Freeze_o=1, Stall_o=0, Busy_o=1, counter holds; after release the remaining 2 bubbles complete; StallCount_o=5.
- Counter control, CNT_W=4: force 20 stall cycles -> StallCount_o saturates at 15; ClrCnt_i=1 concurrent with a stall -> StallCount_o=0 next cycle.
